// File: rtl/bz_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// bz_deserializer_pkg
// Shared router definitions used by the packet deserializer:
//   - router packet width and field positions
//   - the route-31 header constant
//   - the deserializer FSM state encoding
// -----------------------------------------------------------------------------
package bz_deserializer_pkg;

    // Router packet: 11 bits, bit 10 is the tail flag on data packets.
    localparam int PKT_W       = 11;
    localparam int TAIL_BIT    = 10;

    // A header with bit 9 set means "route 31"; the canonical form is 11'h200.
    localparam int              ROUTE31_BIT = 9;
    localparam logic [PKT_W-1:0] HDR_ROUTE31 = 11'h200;

    // Deserializer FSM states.
    typedef enum logic [2:0] {
        HEADER = 3'd0,
        DATA1  = 3'd1,
        DATA2  = 3'd2,
        DATA3  = 3'd3,
        SEND   = 3'd4
    } state_t;

endpackage

// File: rtl/bz_deserializer.sv
// -----------------------------------------------------------------------------
// bz_deserializer
// Reassembles router packets popped from a show-ahead FIFO into one core word
// [route | code | payload] and offers it on a valid/ack channel.
//
// Packet stream: header {6'b0, route[4:0]} (or 11'h200 for route 31), then
// DATA1 {tail, 3'b0, f[26:20]}, DATA2 {tail, f[19:10]}, DATA3 {tail, f[9:0]},
// where f is the 27-bit code+payload field. A DATA3 tail of 0 means the next
// word reuses the current route and starts directly at DATA1.
//
// Channel handshake: PC_out_channel_v is high while a word is offered and the
// word is held stable until a cycle with v=1 and a=1; a is ignored while v=0.
//
// Ports:
//   clk                 clock
//   reset               asynchronous, active-high reset
//   data_in[10:0]       packet at the FIFO head, valid while is_empty=0
//   is_empty            FIFO empty flag
//   rdreq               FIFO pop; a packet is consumed when rdreq=1, is_empty=0
//   PC_out_channel_d    word to the core
//   PC_out_channel_v    word valid
//   PC_out_channel_a    word accepted by the core
//   framing_err         one-cycle pulse on a protocol violation
// -----------------------------------------------------------------------------
module bz_deserializer
    import bz_deserializer_pkg::*;
#(
    parameter int NPCcode  = 7,
    parameter int NPCdata  = 20,
    parameter int NPCroute = 5
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [PKT_W-1:0]                     data_in,
    input  logic                                 is_empty,
    output logic                                 rdreq,
    output logic [NPCroute+NPCcode+NPCdata-1:0]  PC_out_channel_d,
    output logic                                 PC_out_channel_v,
    input  logic                                 PC_out_channel_a,
    output logic                                 framing_err
);

    // The packet format carries a fixed 27-bit code+payload field split as
    // 7|10|10 over the three data packets.
    localparam int WORD_W = NPCroute + NPCcode + NPCdata;

    state_t              state_q;
    logic [NPCroute-1:0] route_q;
    logic [6:0]          hi_q;         // field bits [26:20] from DATA1
    logic [9:0]          mid_q;        // field bits [19:10] from DATA2
    logic                last_tail_q;
    logic [WORD_W-1:0]   d_q;
    logic                v_q;
    logic                framing_err_q;

    logic pkt_tail;
    assign pkt_tail = data_in[TAIL_BIT];

    // Pop whenever a packet is available and no word is waiting to be sent.
    assign rdreq = !reset && !is_empty && (state_q != SEND);

    assign PC_out_channel_d = d_q;
    assign PC_out_channel_v = v_q;
    assign framing_err      = framing_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HEADER;
            route_q       <= '0;
            hi_q          <= '0;
            mid_q         <= '0;
            last_tail_q   <= 1'b1;
            d_q           <= '0;
            v_q           <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            framing_err_q <= 1'b0;
            case (state_q)
                HEADER: begin
                    if (!is_empty) begin
                        if (pkt_tail) begin
                            // A tail bit on a header is illegal; drop it and
                            // keep looking for a header.
                            framing_err_q <= 1'b1;
                        end else begin
                            route_q <= data_in[ROUTE31_BIT] ? '1
                                                            : data_in[NPCroute-1:0];
                            state_q <= DATA1;
                        end
                    end
                end
                DATA1: begin
                    if (!is_empty) begin
                        if (pkt_tail) begin
                            framing_err_q <= 1'b1;
                            state_q       <= HEADER;
                        end else begin
                            hi_q    <= data_in[6:0];
                            state_q <= DATA2;
                        end
                    end
                end
                DATA2: begin
                    if (!is_empty) begin
                        if (pkt_tail) begin
                            framing_err_q <= 1'b1;
                            state_q       <= HEADER;
                        end else begin
                            mid_q   <= data_in[9:0];
                            state_q <= DATA3;
                        end
                    end
                end
                DATA3: begin
                    if (!is_empty) begin
                        // The last slice goes straight into the output word so
                        // v can rise in the cycle after this pop.
                        last_tail_q <= pkt_tail;
                        d_q         <= {route_q, hi_q, mid_q, data_in[9:0]};
                        v_q         <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (PC_out_channel_a) begin
                        v_q     <= 1'b0;
                        state_q <= last_tail_q ? HEADER : DATA1;
                    end
                end
                default: begin
                    state_q <= HEADER;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bz_deserializer.sv
// -----------------------------------------------------------------------------
// tb_bz_deserializer
// Directed bench: a queue models the show-ahead FIFO, a scoreboard queue holds
// the words the core side should receive, and counters track transfers and
// framing error pulses.
// -----------------------------------------------------------------------------
module tb_bz_deserializer;

    logic        clk;
    logic        reset;
    logic [10:0] data_in;
    logic        is_empty;
    logic        rdreq;
    logic [31:0] PC_out_channel_d;
    logic        PC_out_channel_v;
    logic        PC_out_channel_a;
    logic        framing_err;

    bz_deserializer dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .is_empty         (is_empty),
        .rdreq            (rdreq),
        .PC_out_channel_d (PC_out_channel_d),
        .PC_out_channel_v (PC_out_channel_v),
        .PC_out_channel_a (PC_out_channel_a),
        .framing_err      (framing_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    logic [10:0] pkt_q[$];
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int xfer_cnt = 0;
    int fe_cnt   = 0;
    int last_pop_cyc = 0;
    int v_rise_cyc   = 0;
    logic v_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- FIFO model and channel monitor ----------------
    initial begin
        logic        pop_pend;
        logic        xfer_pend;
        logic [31:0] d_capt;
        is_empty = 1'b1;
        data_in  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pkt_q.size() > 0) begin
                is_empty = 1'b0;
                data_in  = pkt_q[0];
            end else begin
                is_empty = 1'b1;
                data_in  = '0;
            end
            #1;
            pop_pend  = rdreq && !is_empty;
            xfer_pend = PC_out_channel_v && PC_out_channel_a && !reset;
            d_capt    = PC_out_channel_d;
            if (framing_err) fe_cnt++;
            if (PC_out_channel_v && !v_prev) v_rise_cyc = cyc;
            v_prev = PC_out_channel_v;
            @(posedge clk);
            if (pop_pend) begin
                void'(pkt_q.pop_front());
                last_pop_cyc = cyc;
            end
            if (xfer_pend) begin
                xfer_cnt++;
                if (exp_q.size() > 0) check("xfer_d", d_capt, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push4(input logic [10:0] p0, input logic [10:0] p1,
                         input logic [10:0] p2, input logic [10:0] p3);
        pkt_q.push_back(p0);
        pkt_q.push_back(p1);
        pkt_q.push_back(p2);
        pkt_q.push_back(p3);
    endtask

    // Wait (bounded) until the FIFO is drained, no word is pending and every
    // expected word has arrived.
    task automatic settle(input string tag);
        int n = 0;
        while ((pkt_q.size() != 0 || PC_out_channel_v || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        check(tag, pkt_q.size() + exp_q.size() + 32'(PC_out_channel_v), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int x0;
        int f0;
        int n;
        reset            = 1'b1;
        PC_out_channel_a = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        #2;
        check("rst_rdreq", 32'(rdreq), 0);
        check("rst_v", 32'(PC_out_channel_v), 0);
        check("rst_d", PC_out_channel_d, 32'h0);
        check("rst_ferr", 32'(framing_err), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic word with a header, and first-word latency.
        x0 = xfer_cnt; f0 = fe_cnt;
        push4(11'h003, 11'h012, 11'h2AF, 11'h4DE);
        exp_q.push_back(32'h192ABCDE);
        settle("t1_settle");
        check("t1_nxfer", xfer_cnt - x0, 1);
        check("t1_v_latency", v_rise_cyc - last_pop_cyc, 1);
        check("t1_ferr", fe_cnt - f0, 0);

        // Route-31 header.
        x0 = xfer_cnt;
        push4(11'h200, 11'h012, 11'h2AF, 11'h4DE);
        exp_q.push_back(32'hF92ABCDE);
        settle("t2_settle");
        check("t2_nxfer", xfer_cnt - x0, 1);

        // Two words under one header, then a fresh header.
        x0 = xfer_cnt;
        push4(11'h003, 11'h012, 11'h2AF, 11'h0DE);
        pkt_q.push_back(11'h012);
        pkt_q.push_back(11'h2AF);
        pkt_q.push_back(11'h4DE);
        push4(11'h005, 11'h012, 11'h2AF, 11'h4DE);
        exp_q.push_back(32'h192ABCDE);
        exp_q.push_back(32'h192ABCDE);
        exp_q.push_back(32'h292ABCDE);
        settle("t3_settle");
        check("t3_nxfer", xfer_cnt - x0, 3);

        // Back-pressure: a held low for 5 cycles while a packet waits.
        x0 = xfer_cnt;
        PC_out_channel_a = 1'b0;
        push4(11'h003, 11'h012, 11'h2AF, 11'h4DE);
        pkt_q.push_back(11'h005);
        exp_q.push_back(32'h192ABCDE);
        n = 0;
        while (!PC_out_channel_v && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t4_v_seen", 32'(PC_out_channel_v), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("t4_hold_v", 32'(PC_out_channel_v), 1);
            check("t4_hold_d", PC_out_channel_d, 32'h192ABCDE);
            check("t4_hold_rdreq", 32'(rdreq), 0);
        end
        check("t4_no_early_xfer", xfer_cnt - x0, 0);
        @(negedge clk);
        PC_out_channel_a = 1'b1;
        @(negedge clk);
        #2;
        check("t4_v_drop", 32'(PC_out_channel_v), 0);
        check("t4_nxfer", xfer_cnt - x0, 1);
        pkt_q.push_back(11'h012);
        pkt_q.push_back(11'h2AF);
        pkt_q.push_back(11'h4DE);
        exp_q.push_back(32'h292ABCDE);
        settle("t4_settle");

        // Tail on DATA1 -> framing error, then a clean word.
        x0 = xfer_cnt; f0 = fe_cnt;
        pkt_q.push_back(11'h003);
        pkt_q.push_back(11'h412);
        push4(11'h005, 11'h012, 11'h2AF, 11'h4DE);
        exp_q.push_back(32'h292ABCDE);
        settle("t5_settle");
        check("t5_nxfer", xfer_cnt - x0, 1);
        check("t5_ferr", fe_cnt - f0, 1);

        // Tail on a header -> framing error, stay in HEADER.
        x0 = xfer_cnt; f0 = fe_cnt;
        pkt_q.push_back(11'h403);
        push4(11'h003, 11'h012, 11'h2AF, 11'h4DE);
        exp_q.push_back(32'h192ABCDE);
        settle("t6_settle");
        check("t6_nxfer", xfer_cnt - x0, 1);
        check("t6_ferr", fe_cnt - f0, 1);

        // Tail on DATA2 -> framing error, partial word dropped.
        x0 = xfer_cnt; f0 = fe_cnt;
        pkt_q.push_back(11'h003);
        pkt_q.push_back(11'h012);
        pkt_q.push_back(11'h6AF);
        push4(11'h200, 11'h012, 11'h2AF, 11'h4DE);
        exp_q.push_back(32'hF92ABCDE);
        settle("t7_settle");
        check("t7_nxfer", xfer_cnt - x0, 1);
        check("t7_ferr", fe_cnt - f0, 1);

        // Reset after the DATA2 pop discards the partial word.
        x0 = xfer_cnt;
        pkt_q.push_back(11'h003);
        pkt_q.push_back(11'h012);
        pkt_q.push_back(11'h2AF);
        n = 0;
        while (pkt_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t8_drained", pkt_q.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        push4(11'h005, 11'h012, 11'h2AF, 11'h4DE);
        #2;
        check("t8_rst_v", 32'(PC_out_channel_v), 0);
        check("t8_rst_d", PC_out_channel_d, 32'h0);
        @(negedge clk);
        #2;
        check("t8_rst_rdreq", 32'(rdreq), 0);
        check("t8_rst_v2", 32'(PC_out_channel_v), 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(32'h292ABCDE);
        settle("t8_settle");
        check("t8_nxfer", xfer_cnt - x0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bz_deserializer.md
BZ_DESERIALIZER -- requirements
Module: bz_deserializer

Interface
REQ-001 SHALL have parameter NPCcode, default 7, code field width of the core word.
REQ-002 SHALL have parameter NPCdata, default 20, payload field width of the core word.
REQ-003 SHALL have parameter NPCroute, default 5, route field width of the core word.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port data_in  input  11  router packet at the head of a show-ahead FIFO; valid whenever is_empty=0.
REQ-007 SHALL have port is_empty  input  1  FIFO empty flag.
REQ-008 SHALL have port rdreq  output  1  FIFO pop; a packet is consumed in any cycle with rdreq=1 and is_empty=0.
REQ-009 SHALL have port PC_out_channel  Channel  d[31:0] out, v out, a in  word to the core, packed as [route | code | payload] = 5|7|20.
REQ-010 SHALL have port framing_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-011 SHALL accept this packet stream: header {6'b0, route[4:0]} or 11'h200 (route 31), then DATA1 {tail, 3'b0, d[26:20]}, then DATA2 {tail, d[19:10]}, then DATA3 {tail, d[9:0]}.
REQ-012 SHALL use an FSM with states HEADER, DATA1, DATA2, DATA3 and SEND.
REQ-013 SHALL drive rdreq = !is_empty in HEADER, DATA1, DATA2 and DATA3, and rdreq = 0 in SEND.
REQ-014 SHALL hold its state with no register updates in any cycle where is_empty=1.
REQ-015 SHALL latch the route on a header pop: 5'h1F if data_in[9]=1, otherwise data_in[4:0]; next state DATA1.
REQ-016 SHALL, on DATA1/DATA2/DATA3 pops, latch bits [26:20], [19:10] and [9:0] of the 27-bit code+payload field respectively; DATA1 bits [9:7] are ignored.
REQ-017 SHALL, on the DATA3 pop, latch data_in[10] as last_tail and go to SEND.
REQ-018 SHALL assert v=1 in SEND with d = {route, code, payload}, holding d stable until the transfer.
REQ-019 SHALL complete a transfer in a cycle with v=1 and a=1; next state HEADER if last_tail=1, else DATA1 with the route retained.
REQ-020 SHALL assert v in the cycle after the DATA3 pop; minimum 5 cycles per word with a header and 4 without.
REQ-021 SHALL treat tail=1 on a DATA1 or DATA2 pop as a framing error: pulse framing_err, discard the partial word, go to HEADER.
REQ-022 SHALL treat data_in[10]=1 on a header pop as a framing error: pulse framing_err, stay in HEADER.
REQ-023 SHALL ignore a while v=0.

Reset
REQ-024 SHALL, on reset, force state HEADER, rdreq=0, v=0, d=32'h0, framing_err=0, last_tail=1 and the route register to 0.
REQ-025 SHALL discard any partial or unsent word on reset mid-operation; the first packet popped after reset is decoded as a header.

Structure
REQ-026 SHALL take these from the shared router package: packet width 11, tail bit index 10, route-31 header constant 11'h200, route-31 flag bit 9, and the FSM state enum.
REQ-027 SHALL be a single module with one FSM and datapath registers; no sub-module is warranted.

Verification
REQ-028 Packets 0x003, 0x012, 0x2AF, 0x4DE -> one transfer, d=0x192ABCDE, v asserted the cycle after the 0x4DE pop.
REQ-029 Packets 0x200, 0x012, 0x2AF, 0x4DE -> d=0xF92ABCDE (route 5'h1F).
REQ-030 Packets 0x003, 0x012, 0x2AF, 0x0DE, 0x012, 0x2AF, 0x4DE -> two transfers of 0x192ABCDE, no header between them, next packet decoded as a header.
REQ-031 a held 0 for 5 cycles in SEND -> v=1, d constant, rdreq=0 throughout; the transfer completes in the cycle a rises.
REQ-032 Packets 0x003, 0x412 -> framing_err pulse, no transfer; following packets 0x005, 0x012, 0x2AF, 0x4DE -> d=0x292ABCDE.
REQ-033 Reset asserted after the DATA2 pop, then a full 4-packet word -> v=0 during reset and exactly one correct transfer afterwards.
